// File: rtl/i2s_pkg.sv
// Shared state type, width helpers and parameter legality for the I2S frame engine.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package i2s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of the system-clock-per-BCLK divider.
  function automatic int div_cnt_w(input int bclk_div);
    return cnt_width(bclk_div);
  endfunction

  // Width of the BCLK-period-in-frame counter (0..2*slot_w-1).
  function automatic int frame_cnt_w(input int slot_w);
    return cnt_width(2 * slot_w);
  endfunction

  // A slot needs one spare BCLK for the I2S delay bit; the divider must split evenly.
  function automatic bit params_legal(input int data_w, input int slot_w, input int bclk_div);
    return (data_w >= 2) && (data_w <= 32) && (slot_w >= data_w + 1) &&
           (bclk_div >= 2) && ((bclk_div % 2) == 0);
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK divider: counts system clocks per BCLK period and strobes fall/rise/last cycles.
// Latency: strobes are combinational from the divider register; o_bclk follows it directly.
// Backpressure: none; runs whenever i_en is high, parks at zero when low.
module i2s_bclk_gen
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_bclk,
  output logic o_fall,
  output logic o_rise,
  output logic o_last
);

  localparam int CW = div_cnt_w(BCLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(BCLK_DIV / 2);
  localparam logic [CW-1:0] LAST = CW'(BCLK_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;

  // Wrap the divider while enabled; hold it cleared otherwise so a restart begins on a fall.
  always_comb begin
    div_cnt_d = '0;
    if (i_en) begin
      div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + CW'(1);
    end
  end

  // Divider register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign o_bclk = i_en && (div_cnt_q >= HALF);
  assign o_fall = i_en && (div_cnt_q == '0);
  assign o_rise = i_en && (div_cnt_q == HALF);
  assign o_last = i_en && (div_cnt_q == LAST);

endmodule

// File: rtl/i2s_frame_engine.sv
// I2S master: generates BCLK/LRCK, serialises a stereo TX frame, deserialises a stereo RX frame.
// Latency: TX holding register loads at frame start; RX result valid one cycle after its last bit.
// Backpressure: one-entry TX holding register (valid/ready); RX has none, results hold until next frame.
module i2s_frame_engine
  import i2s_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_mono,
  input  logic              i_tx_valid,
  input  logic [DATA_W-1:0] i_tx_left,
  input  logic [DATA_W-1:0] i_tx_right,
  output logic              o_tx_ready,
  output logic              o_rx_valid,
  output logic [DATA_W-1:0] o_rx_left,
  output logic [DATA_W-1:0] o_rx_right,
  output logic              o_underrun,
  output logic              o_bclk,
  output logic              o_lrck,
  output logic              o_dacdat,
  input  logic              i_adcdat
);

  localparam int KW = frame_cnt_w(SLOT_W);
  localparam logic [KW-1:0] K_LAST   = KW'(2 * SLOT_W - 1);
  localparam logic [KW-1:0] K_SLOT   = KW'(SLOT_W);
  localparam logic [KW-1:0] K_RXDONE = KW'(SLOT_W + DATA_W);
  localparam logic [KW-1:0] P_DATA   = KW'(DATA_W);

  if (!params_legal(DATA_W, SLOT_W, BCLK_DIV)) begin : g_bad_params
    $error("i2s_frame_engine: illegal DATA_W/SLOT_W/BCLK_DIV combination");
  end

  state_t            state_q, state_d;
  logic              active;
  logic              fall, rise, last, frame_end, load, tx_xfer, rx_done;
  logic [KW-1:0]     k_q, k_d, k_nxt, p_cur, p_nxt;
  logic              rx_win, tx_win;

  logic              hold_full_q;
  logic [DATA_W-1:0] hold_l_q, hold_r_q;
  logic [DATA_W-1:0] tx_sh_l_q, tx_sh_r_q;
  logic              dacdat_q, lrck_q, underrun_q;
  logic [DATA_W-1:0] rx_sh_l_q, rx_sh_r_q, rx_l_d, rx_r_d;
  logic [DATA_W-1:0] rx_left_q, rx_right_q;
  logic              rx_valid_q;

  i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (active),
    .o_bclk (o_bclk),
    .o_fall (fall),
    .o_rise (rise),
    .o_last (last)
  );

  assign frame_end = last && (k_q == K_LAST);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: stopping is only allowed on a frame boundary, so a started frame always completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_en) state_d = ST_RUN;
      ST_RUN:   if (!i_en) state_d = frame_end ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (i_en)           state_d = ST_RUN;
        else if (frame_end) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: the bit clock runs in both RUN and DRAIN.
  always_comb begin
    active = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  end

  // BCLK period index within the frame, plus slot positions for this and the next period.
  always_comb begin
    k_nxt  = (k_q == K_LAST) ? '0 : k_q + KW'(1);
    k_d    = last ? k_nxt : k_q;
    p_cur  = (k_q >= K_SLOT) ? k_q - K_SLOT : k_q;
    p_nxt  = (k_nxt >= K_SLOT) ? k_nxt - K_SLOT : k_nxt;
    rx_win = (p_cur != '0) && (p_cur <= P_DATA);
    tx_win = (p_nxt != '0) && (p_nxt <= P_DATA);
  end

  // Frame position register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

  assign load    = fall && (k_q == '0);
  assign tx_xfer = i_tx_valid && !hold_full_q;

  // TX holding register: emptied by a frame-start load, refilled by a handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
    end else if (load && hold_full_q) begin
      hold_full_q <= 1'b0;
    end else if (tx_xfer) begin
      hold_full_q <= 1'b1;
      hold_l_q    <= i_tx_left;
      hold_r_q    <= i_tx_right;
    end
  end

  // TX serialiser: LRCK/DACDAT are prepared on the last system clock so they change with BCLK's fall.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_sh_l_q  <= '0;
      tx_sh_r_q  <= '0;
      dacdat_q   <= 1'b0;
      lrck_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= load && !hold_full_q;
      if (load) begin
        if (hold_full_q) begin
          tx_sh_l_q <= hold_l_q;
          tx_sh_r_q <= i_mono ? hold_l_q : hold_r_q;
        end else begin
          tx_sh_l_q <= '0;
          tx_sh_r_q <= '0;
        end
      end else if (last) begin
        lrck_q <= (k_nxt >= K_SLOT);
        if (!tx_win) begin
          dacdat_q <= 1'b0;
        end else if (k_nxt >= K_SLOT) begin
          dacdat_q  <= tx_sh_r_q[DATA_W-1];
          tx_sh_r_q <= tx_sh_r_q << 1;
        end else begin
          dacdat_q  <= tx_sh_l_q[DATA_W-1];
          tx_sh_l_q <= tx_sh_l_q << 1;
        end
      end
    end
  end

  // RX deserialiser next values: sample ADCDAT on BCLK rise inside the data window, MSB first.
  always_comb begin
    rx_l_d = rx_sh_l_q;
    rx_r_d = rx_sh_r_q;
    if (rise && rx_win) begin
      if (k_q >= K_SLOT) rx_r_d = {rx_sh_r_q[DATA_W-2:0], i_adcdat};
      else               rx_l_d = {rx_sh_l_q[DATA_W-2:0], i_adcdat};
    end
  end

  assign rx_done = rise && (k_q == K_RXDONE);

  // RX registers: publish both channels once the right channel's last bit is in.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_sh_l_q  <= '0;
      rx_sh_r_q  <= '0;
      rx_left_q  <= '0;
      rx_right_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_sh_l_q  <= rx_l_d;
      rx_sh_r_q  <= rx_r_d;
      rx_valid_q <= rx_done;
      if (rx_done) begin
        rx_left_q  <= rx_l_d;
        rx_right_q <= rx_r_d;
      end
    end
  end

  assign o_tx_ready = !hold_full_q;
  assign o_rx_valid = rx_valid_q;
  assign o_rx_left  = rx_left_q;
  assign o_rx_right = rx_right_q;
  assign o_underrun = underrun_q;
  assign o_lrck     = lrck_q;
  assign o_dacdat   = dacdat_q;

endmodule

// File: tb/tb_i2s_frame_engine.sv
// Bench for i2s_frame_engine: cycle-level model of the default build in loopback, plus a fast 24-bit build.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_i2s_frame_engine;

  localparam int DW = 16, SW = 32, DIV = 8, FRAME = 2 * SW * DIV;
  localparam int DWB = 24, SWB = 32, DIVB = 2, FRAMEB = 2 * SWB * DIVB;
  // Model cycle (within a frame) whose end carries the rising edge of the last right-channel bit.
  localparam int RXV_T = (SW + DW) * DIV + DIV / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  // ---------------- default build, loopback ----------------
  logic rst_a, en_a, mono_a, txv_a;
  logic [DW-1:0] txl_a, txr_a, rxl_a, rxr_a;
  logic tx_rdy_a, rxv_a, und_a, bclk_a, lrck_a, dac_a;

  i2s_frame_engine #(.DATA_W(DW), .SLOT_W(SW), .BCLK_DIV(DIV)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_en(en_a), .i_mono(mono_a),
    .i_tx_valid(txv_a), .i_tx_left(txl_a), .i_tx_right(txr_a), .o_tx_ready(tx_rdy_a),
    .o_rx_valid(rxv_a), .o_rx_left(rxl_a), .o_rx_right(rxr_a), .o_underrun(und_a),
    .o_bclk(bclk_a), .o_lrck(lrck_a), .o_dacdat(dac_a), .i_adcdat(dac_a)
  );

  // ---------------- 24-bit fast build, loopback ----------------
  logic rst_b, en_b, mono_b, txv_b;
  logic [DWB-1:0] txl_b, txr_b, rxl_b, rxr_b;
  logic tx_rdy_b, rxv_b, und_b, bclk_b, lrck_b, dac_b;

  i2s_frame_engine #(.DATA_W(DWB), .SLOT_W(SWB), .BCLK_DIV(DIVB)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_en(en_b), .i_mono(mono_b),
    .i_tx_valid(txv_b), .i_tx_left(txl_b), .i_tx_right(txr_b), .o_tx_ready(tx_rdy_b),
    .o_rx_valid(rxv_b), .o_rx_left(rxl_b), .o_rx_right(rxr_b), .o_underrun(und_b),
    .o_bclk(bclk_b), .o_lrck(lrck_b), .o_dacdat(dac_b), .i_adcdat(dac_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc_cnt);
    end
  endtask

  // ---------------- behavioural model of the default build ----------------
  // m_t: -1 when stopped, else system-clock index within the current frame.
  int m_t = -1;
  bit m_full = 0, m_rxv = 0, m_und = 0, m_xfer;
  logic [DW-1:0] m_hl = '0, m_hr = '0, m_cl = '0, m_cr = '0, m_rl = '0, m_rr = '0;

  always @(posedge clk) begin
    if (rst_a) begin
      m_t = -1; m_full = 0; m_rxv = 0; m_und = 0;
    end else begin
      m_xfer = txv_a && !m_full;
      m_rxv = 0;
      m_und = 0;
      if (m_t == 0) begin
        if (m_full) begin
          m_cl = m_hl; m_cr = mono_a ? m_hl : m_hr; m_full = 0;
        end else begin
          m_cl = '0; m_cr = '0; m_und = 1;
        end
      end
      if (m_t == RXV_T) begin
        m_rxv = 1; m_rl = m_cl; m_rr = m_cr;
      end
      if (m_xfer) begin
        m_full = 1; m_hl = txl_a; m_hr = txr_a;
      end
      if (m_t < 0)               m_t = en_a ? 0 : -1;
      else if (m_t == FRAME - 1) m_t = en_a ? 0 : -1;
      else                       m_t = m_t + 1;
    end
  end

  // Compare process: every cycle once reset has been applied.
  bit cmp_on = 0;
  int kk, pp;
  logic e_bclk, e_lrck, e_dac;
  always @(negedge clk) begin
    if (cmp_on) begin
      e_bclk = 0; e_lrck = 0; e_dac = 0;
      if (m_t >= 0) begin
        kk = m_t / DIV;
        pp = kk % SW;
        e_bclk = (m_t % DIV) >= (DIV / 2);
        e_lrck = kk >= SW;
        if (pp >= 1 && pp <= DW) e_dac = (kk >= SW) ? m_cr[DW-pp] : m_cl[DW-pp];
      end
      check("bclk", bclk_a, e_bclk);
      check("lrck", lrck_a, e_lrck);
      check("dacdat", dac_a, e_dac);
      check("tx_ready", tx_rdy_a, !m_full);
      check("underrun", und_a, m_und);
      check("rx_valid", rxv_a, m_rxv);
      if (m_rxv) begin
        check("rx_left", rxl_a, m_rl);
        check("rx_right", rxr_a, m_rr);
      end
    end
  end

  int rxv_cnt_a = 0, und_cnt_a = 0, und_cnt_b = 0;
  always @(posedge clk) begin
    if (rxv_a === 1'b1) rxv_cnt_a++;
    if (und_a === 1'b1) und_cnt_a++;
    if (und_b === 1'b1) und_cnt_b++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_a(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int n = 0;
    while (tx_rdy_a !== 1'b1 && n < 2 * FRAME) begin @(negedge clk); n++; end
    check("push_a_ready", tx_rdy_a, 1);
    txl_a = l; txr_a = r; txv_a = 1;
    @(negedge clk);
    txv_a = 0;
  endtask

  task automatic wait_rxv_a(output int stamp);
    int n = 0;
    while (rxv_a !== 1'b1 && n < 2 * FRAME) begin @(negedge clk); n++; end
    check("rxv_a_wait", rxv_a, 1);
    stamp = cyc_cnt;
    @(negedge clk);
  endtask

  task automatic wait_lrck_a(input logic from_v);
    int n = 0;
    logic prev;
    prev = lrck_a;
    while (!(prev === from_v && lrck_a === !from_v) && n < 2 * FRAME) begin
      prev = lrck_a; @(negedge clk); n++;
    end
    check("lrck_edge_wait", lrck_a, !from_v);
  endtask

  task automatic wait_rxv_b(output int stamp);
    int n = 0;
    while (rxv_b !== 1'b1 && n < 2 * FRAMEB) begin @(negedge clk); n++; end
    check("rxv_b_wait", rxv_b, 1);
    stamp = cyc_cnt;
    @(negedge clk);
  endtask

  int t1, t2, t3, t4, snap;

  initial begin
    rst_a = 1; en_a = 0; mono_a = 0; txv_a = 0; txl_a = '0; txr_a = '0;
    rst_b = 1; en_b = 0; mono_b = 0; txv_b = 0; txl_b = '0; txr_b = '0;
    cyc(3);
    cmp_on = 1;
    check("rst_tx_ready", tx_rdy_a, 1);
    check("rst_bclk", bclk_a, 0);
    check("rst_lrck", lrck_a, 0);
    check("rst_dacdat", dac_a, 0);
    check("rst_rx_valid", rxv_a, 0);
    check("rst_underrun", und_a, 0);
    check("rst_rx_left", rxl_a, 0);
    check("rst_rx_right", rxr_a, 0);

    // Start with an empty holding register; data offered in the load cycle goes to frame 2.
    rst_a = 0; en_a = 1;
    cyc(1);
    push_a(16'hA5C3, 16'h1234);
    wait_rxv_a(t1);
    check("uf_rx_left", rxl_a, 16'h0000);
    check("uf_rx_right", rxr_a, 16'h0000);
    check("uf_underrun_cnt", und_cnt_a, 1);

    // Left MSB (1) is driven during the second BCLK after LRCK falls.
    wait_lrck_a(1'b1);
    cyc(DIV - 1);
    check("msb_k0", dac_a, 0);
    cyc(1);
    check("msb_k1", dac_a, 1);

    push_a(16'h8001, 16'h7FFF);
    mono_a = 1;
    wait_rxv_a(t2);
    check("lb_rx_left", rxl_a, 16'hA5C3);
    check("lb_rx_right", rxr_a, 16'h1234);
    check("frame_period", t2 - t1, 512);

    wait_rxv_a(t3);
    check("mono_rx_left", rxl_a, 16'h8001);
    check("mono_rx_right", rxr_a, 16'h8001);
    mono_a = 0;
    check("underrun_cnt_3f", und_cnt_a, 1);

    // Drop the run request at k=10 of frame 4; that frame still completes.
    push_a(16'h1111, 16'h2222);
    wait_lrck_a(1'b1);
    cyc(10 * DIV);
    en_a = 0;
    wait_rxv_a(t4);
    check("drain_rx_left", rxl_a, 16'h1111);
    check("drain_rx_right", rxr_a, 16'h2222);
    snap = rxv_cnt_a;
    cyc(FRAME + 100);
    check("drain_no_rxv", rxv_cnt_a, snap);
    check("drain_bclk", bclk_a, 0);
    check("drain_lrck", lrck_a, 0);

    // Reset in the middle of the right slot aborts the frame.
    push_a(16'h0F0F, 16'hF0F0);
    en_a = 1;
    wait_lrck_a(1'b0);
    cyc(20);
    snap = rxv_cnt_a;
    rst_a = 1; en_a = 0;
    cyc(1);
    check("abort_tx_ready", tx_rdy_a, 1);
    check("abort_bclk", bclk_a, 0);
    check("abort_lrck", lrck_a, 0);
    check("abort_dacdat", dac_a, 0);
    check("abort_rx_left", rxl_a, 0);
    rst_a = 0;
    cyc(FRAME);
    check("abort_no_rxv", rxv_cnt_a, snap);
    push_a(16'h3C3C, 16'hC3C3);
    en_a = 1;
    wait_rxv_a(t1);
    check("restart_rx_left", rxl_a, 16'h3C3C);
    check("restart_rx_right", rxr_a, 16'hC3C3);
    en_a = 0;

    // 24-bit build with BCLK = clk/2.
    rst_b = 0;
    cyc(2);
    check("b_ready", tx_rdy_b, 1);
    txl_b = 24'h800001; txr_b = 24'h7FFFFE; txv_b = 1;
    cyc(1);
    txv_b = 0;
    en_b = 1;
    wait_rxv_b(t1);
    check("b_rx_left", rxl_b, 24'h800001);
    check("b_rx_right", rxr_b, 24'h7FFFFE);
    wait_rxv_b(t2);
    check("b_period", t2 - t1, 128);
    check("b_uf_rx_left", rxl_b, 0);
    check("b_uf_rx_right", rxr_b, 0);
    check("b_underrun_cnt", und_cnt_b, 1);
    en_b = 0;
    cyc(FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
